bnn_neuron_array: RTL and testbench

Parametrised successor of the single-neuron binary compute unit. NEURONS binary neurons run in parallel over a shared stream of IN_W-bit activation beats. Each neuron computes an XNOR-popcount against its own weight slice and keeps a saturating signed accumulator over a configurable number of beats. At the end of each pass it produces a thresholded sign bit per neuron, which feeds the layer register file or the output-class stage.

---
 rtl/bnn_neuron_array_if.sv | 43 ++++
 rtl/bnn_neuron_array.sv | 136 +++++++++++++
 tb/tb_bnn_neuron_array.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_neuron_array_if.sv
// Handshake bundle for bnn_neuron_array: config/start, activation stream, result.
// Latency: none, wires only. Backpressure: x_valid/x_ready on input, out_valid/out_ready on output.
// BNN_ARGMAX_EN adds the argmax class-select output.
interface bnn_neuron_array_if #(
  parameter int NEURONS = 4,
  parameter int IN_W    = 9,
  parameter int ACC_W   = 15,
  parameter int BEATS_W = 7
);
  localparam int AM_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  logic [BEATS_W-1:0]        cfg_beats;
  logic signed [ACC_W-1:0]   cfg_thresh;
  logic                      start;
  logic                      busy;
  logic                      x_valid;
  logic                      x_ready;
  logic [IN_W-1:0]           x_data;
  logic [NEURONS*IN_W-1:0]   w_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [NEURONS-1:0]        out_bits;
  logic [NEURONS*ACC_W-1:0]  out_acc;
`ifdef BNN_ARGMAX_EN
  logic [AM_W-1:0]           argmax;
`endif

  modport master (
    output cfg_beats, cfg_thresh, start, x_valid, x_data, w_data, out_ready,
    input  busy, x_ready, out_valid, out_bits, out_acc
`ifdef BNN_ARGMAX_EN
    , input argmax
`endif
  );

  modport slave (
    input  cfg_beats, cfg_thresh, start, x_valid, x_data, w_data, out_ready,
    output busy, x_ready, out_valid, out_bits, out_acc
`ifdef BNN_ARGMAX_EN
    , output argmax
`endif
  );
endinterface

// File: rtl/bnn_neuron_array.sv
// Parallel XNOR-popcount binary neurons with saturating accumulators and thresholded sign out.
// Latency: result valid one cycle after the last accepted beat. Backpressure: x_ready only in ACCUM;
// result held until out_ready. Optional BNN_ARGMAX_EN registers the index of the largest accumulator.
module bnn_neuron_array #(
  parameter int NEURONS = 4,
  parameter int IN_W    = 9,
  parameter int ACC_W   = 15,
  parameter int BEATS_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  bnn_neuron_array_if.slave  bus
);
  // Two guard bits so acc + contrib never overflows before the clamp.
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state_q, state_nxt;
  logic [BEATS_W-1:0]      beats_q, cnt_q;
  logic signed [ACC_W-1:0] thresh_q;
  logic signed [ACC_W-1:0] acc_q   [NEURONS];
  logic signed [ACC_W-1:0] acc_nxt [NEURONS];
  logic [NEURONS-1:0]      bits_q;
  logic [NEURONS*ACC_W-1:0] acc_flat;
  logic                    start_acc, beat_acc, last_beat;
  logic                    zero_pass_bit;
  logic [IN_W-1:0]         agree;
  logic signed [SW-1:0]    pop, sum;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    start_acc = 1'b0;
    beat_acc  = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        start_acc = 1'b1;
        state_nxt = (bus.cfg_beats == '0) ? DONE : ACCUM;
      end
      ACCUM: if (bus.x_valid) begin
        beat_acc = 1'b1;
        if (cnt_q == beats_q - BEATS_W'(1)) begin
          last_beat = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.x_ready   = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_bits  = bits_q;
  assign bus.out_acc   = acc_flat;

  // contrib = 2*agreements - IN_W, then clamp to the signed accumulator range.
  always_comb begin
    agree = '0;
    pop   = '0;
    sum   = '0;
    for (int n = 0; n < NEURONS; n++) begin
      agree = ~(bus.x_data ^ bus.w_data[n*IN_W +: IN_W]);
      pop   = '0;
      for (int i = 0; i < IN_W; i++) pop = pop + SW'(agree[i]);
      sum = {{2{acc_q[n][ACC_W-1]}}, acc_q[n]} + (pop <<< 1) - SW'(IN_W);
      if (sum > SAT_HI)      acc_nxt[n] = SAT_HI[ACC_W-1:0];
      else if (sum < SAT_LO) acc_nxt[n] = SAT_LO[ACC_W-1:0];
      else                   acc_nxt[n] = sum[ACC_W-1:0];
    end
  end

  always_comb begin
    acc_flat = '0;
    for (int n = 0; n < NEURONS; n++) acc_flat[n*ACC_W +: ACC_W] = acc_q[n];
  end

  // Zero-beat pass: every accumulator is 0, so the sign is (0 >= thresh).
  assign zero_pass_bit = bus.cfg_thresh[ACC_W-1] || (bus.cfg_thresh == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q  <= '0;
      cnt_q    <= '0;
      thresh_q <= '0;
      bits_q   <= '0;
      for (int n = 0; n < NEURONS; n++) acc_q[n] <= '0;
    end else if (start_acc) begin
      beats_q  <= bus.cfg_beats;
      thresh_q <= bus.cfg_thresh;
      cnt_q    <= '0;
      bits_q   <= (bus.cfg_beats == '0) ? {NEURONS{zero_pass_bit}} : '0;
      for (int n = 0; n < NEURONS; n++) acc_q[n] <= '0;
    end else if (beat_acc) begin
      cnt_q <= cnt_q + BEATS_W'(1);
      for (int n = 0; n < NEURONS; n++) begin
        acc_q[n] <= acc_nxt[n];
        if (last_beat) bits_q[n] <= (acc_nxt[n] >= thresh_q);
      end
    end
  end

`ifdef BNN_ARGMAX_EN
  localparam int AM_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  logic [AM_W-1:0]         am_nxt, am_q;
  logic signed [ACC_W-1:0] am_best;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    am_nxt  = '0;
    am_best = acc_nxt[0];
    for (int n = 1; n < NEURONS; n++) begin
      if (acc_nxt[n] > am_best) begin
        am_best = acc_nxt[n];
        am_nxt  = AM_W'(n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_acc) am_q <= '0;
    else if (last_beat)   am_q <= am_nxt;
  end

  assign bus.argmax = am_q;
`endif
endmodule

// File: tb/tb_bnn_neuron_array.sv
// Directed bench for bnn_neuron_array: a default-width array plus a 6-bit-accumulator copy
// driven by the same stimulus to exercise saturation.
module tb_bnn_neuron_array;
  logic               clk = 1'b0;
  logic               rst;
  logic [6:0]         cfg_beats;
  logic signed [14:0] cfg_thresh;
  logic               start, x_valid, out_ready;
  logic [8:0]         x_data;
  logic [35:0]        w_data;
  int                 n_tests = 0;
  int                 n_fail  = 0;

  localparam logic [8:0]  X1  = 9'h1FF;
  localparam logic [35:0] W_A = {9'h100, 9'h0FF, 9'h000, 9'h1FF};
  localparam logic [35:0] W_B = {9'h1FF, 9'h1FF, 9'h0FF, 9'h000};

  always #5 clk = ~clk;

  bnn_neuron_array_if #(.NEURONS(4), .IN_W(9), .ACC_W(15), .BEATS_W(7)) bus ();
  bnn_neuron_array_if #(.NEURONS(4), .IN_W(9), .ACC_W(6),  .BEATS_W(7)) sbus ();

  assign bus.cfg_beats   = cfg_beats;
  assign bus.cfg_thresh  = cfg_thresh;
  assign bus.start       = start;
  assign bus.x_valid     = x_valid;
  assign bus.x_data      = x_data;
  assign bus.w_data      = w_data;
  assign bus.out_ready   = out_ready;
  assign sbus.cfg_beats  = cfg_beats;
  assign sbus.cfg_thresh = cfg_thresh[5:0];
  assign sbus.start      = start;
  assign sbus.x_valid    = x_valid;
  assign sbus.x_data     = x_data;
  assign sbus.w_data     = w_data;
  assign sbus.out_ready  = out_ready;

  bnn_neuron_array #(.NEURONS(4), .IN_W(9), .ACC_W(15), .BEATS_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bnn_neuron_array #(.NEURONS(4), .IN_W(9), .ACC_W(6), .BEATS_W(7)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  function automatic logic [59:0] av(input int a3, input int a2, input int a1, input int a0);
    return {15'(a3), 15'(a2), 15'(a1), 15'(a0)};
  endfunction

  function automatic logic [23:0] sv6(input int a3, input int a2, input int a1, input int a0);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [6:0] b, input logic signed [14:0] t);
    cfg_beats  = b;
    cfg_thresh = t;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic beat(input logic [8:0] x, input logic [35:0] w);
    int k;
    x_data  = x;
    w_data  = w;
    x_valid = 1'b1;
    k = 0;
    while (bus.x_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) check("beat_accept", 64'(bus.x_ready), 64'd1);
    tick();
    x_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pass_a(input string tag);
    start_pass(7'd3, 15'sd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    beat(X1, W_A);
    beat(X1, W_A);
    check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
    beat(X1, W_A);
    check({tag, "_latency"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_acc"}, 64'(bus.out_acc), 64'(av(-21, 21, -27, 27)));
    check({tag, "_bits"}, 64'(bus.out_bits), 64'h5);
`ifdef BNN_ARGMAX_EN
    check({tag, "_argmax"}, 64'(bus.argmax), 64'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x_valid = 1'b0; out_ready = 1'b0;
    cfg_beats = '0; cfg_thresh = '0; x_data = '0; w_data = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_xrdy", 64'(bus.x_ready), 64'd0);
    check("rst_oval", 64'(bus.out_valid), 64'd0);
    check("rst_bits", 64'(bus.out_bits), 64'd0);
    check("rst_acc", 64'(bus.out_acc), 64'd0);
`ifdef BNN_ARGMAX_EN
    check("rst_argmax", 64'(bus.argmax), 64'd0);
`endif

    // Basic pass, then results must persist in IDLE.
    pass_a("s1");
    release_result();
    check("s1_idle_oval", 64'(bus.out_valid), 64'd0);
    check("s1_idle_busy", 64'(bus.busy), 64'd0);
    check("s1_retain_acc", 64'(bus.out_acc), 64'(av(-21, 21, -27, 27)));
    check("s1_retain_bits", 64'(bus.out_bits), 64'h5);

    // Input stalls and output backpressure; start in DONE must do nothing.
    start_pass(7'd3, 15'sd0);
    beat(X1, W_A);
    tick();
    beat(X1, W_A);
    tick();
    tick();
    beat(X1, W_A);
    for (int i = 0; i < 5; i++) begin
      check("s2_hold_oval", 64'(bus.out_valid), 64'd1);
      check("s2_hold_xrdy", 64'(bus.x_ready), 64'd0);
      check("s2_hold_acc", 64'(bus.out_acc), 64'(av(-21, 21, -27, 27)));
      check("s2_hold_bits", 64'(bus.out_bits), 64'h5);
      cfg_beats  = 7'd0;
      cfg_thresh = 15'sd100;
      start      = (i == 2);
      tick();
    end
    start = 1'b1;
    release_result();
    start = 1'b0;
    check("s2_start_at_hs", 64'(bus.busy), 64'd0);
    check("s2_idle_oval", 64'(bus.out_valid), 64'd0);
    tick();
    check("s2_still_idle", 64'(bus.busy), 64'd0);

    // Start pulse mid-pass is ignored.
    start_pass(7'd3, 15'sd0);
    beat(X1, W_A);
    cfg_beats = 7'd1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    beat(X1, W_A);
    check("s3_no_early", 64'(bus.out_valid), 64'd0);
    beat(X1, W_A);
    check("s3_done", 64'(bus.out_valid), 64'd1);
    check("s3_acc", 64'(bus.out_acc), 64'(av(-21, 21, -27, 27)));
    release_result();

    // Threshold boundary: n2 ends at 21.
    start_pass(7'd3, 15'sd21);
    repeat (3) beat(X1, W_A);
    check("s4_thr21_bits", 64'(bus.out_bits), 64'h5);
    check("s4_thr21_sbits", 64'(sbus.out_bits), 64'h5);
    release_result();
    start_pass(7'd3, 15'sd22);
    repeat (3) beat(X1, W_A);
    check("s4_thr22_bits", 64'(bus.out_bits), 64'h1);
    release_result();

    // Saturation on the 6-bit copy: +-45 clamps to 31/-32, +-35 to 31/-32.
    start_pass(7'd5, 15'sd0);
    repeat (5) beat(X1, W_A);
    check("s5_wide_acc", 64'(bus.out_acc), 64'(av(-35, 35, -45, 45)));
    check("s5_sat_acc", 64'(sbus.out_acc), 64'(sv6(-32, 31, -32, 31)));
    check("s5_sat_bits", 64'(sbus.out_bits), 64'h5);
    release_result();

    // Tie between n2 and n3 at +9.
    start_pass(7'd1, 15'sd0);
    beat(X1, W_B);
    check("s6_acc", 64'(bus.out_acc), 64'(av(9, 9, 7, -9)));
    check("s6_bits", 64'(bus.out_bits), 64'hE);
`ifdef BNN_ARGMAX_EN
    check("s6_argmax", 64'(bus.argmax), 64'd2);
`endif
    release_result();

    // Zero-beat passes go straight to DONE.
    start_pass(7'd0, 15'sd0);
    check("s7_oval", 64'(bus.out_valid), 64'd1);
    check("s7_xrdy", 64'(bus.x_ready), 64'd0);
    check("s7_acc", 64'(bus.out_acc), 64'd0);
    check("s7_bits", 64'(bus.out_bits), 64'hF);
    release_result();
    start_pass(7'd0, 15'sd1);
    check("s7_thr1_bits", 64'(bus.out_bits), 64'h0);
    release_result();

    // Reset after beat 2 aborts the pass.
    start_pass(7'd3, 15'sd0);
    beat(X1, W_A);
    beat(X1, W_A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s8_busy", 64'(bus.busy), 64'd0);
    check("s8_oval", 64'(bus.out_valid), 64'd0);
    check("s8_acc", 64'(bus.out_acc), 64'd0);
    check("s8_bits", 64'(bus.out_bits), 64'd0);
    pass_a("s8_rerun");
    release_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
